// File: rtl/adder_pkg.sv
// Widths and FSM encoding shared by the adder request arbiter and its users.
package adder_pkg;

   localparam int width    = 8;
   localparam int op_width = 3;
   localparam int RES_W    = 20;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select: purely combinational, zero latency, no backpressure.
// Search starts at ptr and wraps NREQ-1 -> 0; grant is one-hot, or all-zero when req is empty.
module rr_arbiter #(
   parameter int NREQ = 4,
   localparam int IW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx
);

   int   pos;
   logic found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < NREQ; k++) begin
         pos = (int'(ptr) + k) % NREQ;
         if (!found && req[pos]) begin
            grant[pos] = 1'b1;
            idx        = pos[IW-1:0];
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder among NREQ requesters; one op in flight, rsp_valid LAT+1 cycles after accept.
// Backpressure: no new accept until the response is taken; rsp_* hold while rsp_ready is low.
module adder_arbiter #(
   parameter int width    = adder_pkg::width,
   parameter int op_width = adder_pkg::op_width,
   parameter int NREQ     = 4,
   parameter int LAT      = 1
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [NREQ-1:0]              req_valid,
   input  logic [NREQ*width-1:0]        req_a,
   input  logic [NREQ*width-1:0]        req_b,
   input  logic [NREQ*op_width-1:0]     req_op,
   input  logic [NREQ-1:0]              req_mode,
   output logic [NREQ-1:0]              req_ready,
   output logic [width-1:0]             add_a,
   output logic [width-1:0]             add_b,
   output logic [op_width-1:0]          add_op,
   output logic                         add_mode,
   input  logic [adder_pkg::RES_W-1:0]  add_result,
   input  logic                         add_flag,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [$clog2(NREQ)-1:0]      rsp_id,
   output logic [adder_pkg::RES_W-1:0]  rsp_result,
   output logic                         rsp_flag
);

   import adder_pkg::*;

   localparam int IW = $clog2(NREQ);
   localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

   state_t          state, state_nxt;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   win_idx;
   logic [NREQ-1:0] win_grant;
   logic [CW-1:0]   cnt;
   logic            accept;
   logic            done;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (win_grant),
      .idx   (win_idx)
   );

   assign accept    = (state == IDLE) && (|win_grant);
   assign done      = (state == BUSY) && (cnt == '0);
   // rstn gates the grant so nothing looks accepted while reset is held
   assign req_ready = (rstn && (state == IDLE)) ? win_grant : '0;
   assign rsp_valid = (state == RESP);

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept)    state_nxt = BUSY;
         BUSY:    if (done)      state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr        <= '0;
         cnt        <= '0;
         add_a      <= '0;
         add_b      <= '0;
         add_op     <= '0;
         add_mode   <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_flag   <= 1'b0;
      end else begin
         if (accept) begin
            add_a    <= req_a[win_idx*width +: width];
            add_b    <= req_b[win_idx*width +: width];
            add_op   <= req_op[win_idx*op_width +: op_width];
            add_mode <= req_mode[win_idx];
            rsp_id   <= win_idx;
            cnt      <= CW'(LAT);
            ptr      <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
         end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
         end
         // add_* have been stable for LAT cycles here, so the adder output is settled
         if (done) begin
            rsp_result <= add_result;
            rsp_flag   <= add_flag;
         end
      end
   end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameters SHALL be, one per line, as follows.
- width, 8, operand width.
- op_width, 3, opcode width.
- NREQ, 4, number of requesters.
- LAT, 1, adder pipeline latency in cycles; 0 = combinational adder.
REQ-002 Ports SHALL be, one per line, as follows.
- clk  in  1  single clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester request.
- req_a  in  NREQ*width  packed operand A, slice i = requester i.
- req_b  in  NREQ*width  packed operand B.
- req_op  in  NREQ*op_width  packed opcode.
- req_mode  in  NREQ  per-requester mode bit.
- req_ready  out  NREQ  one-hot accept.
- add_a  out  width  operand A to adder.
- add_b  out  width  operand B to adder.
- add_op  out  op_width  opcode to adder.
- add_mode  out  1  mode to adder.
- add_result  in  20  adder result.
- add_flag  in  1  adder flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(NREQ)  index of the served requester.
- rsp_result  out  20  captured add_result.
- rsp_flag  out  1  captured add_flag.

Function
REQ-003 FSM SHALL have three states: IDLE, BUSY, RESP.
REQ-004 IDLE: req_ready SHALL be combinational, one-hot on the round-robin winner among req_valid, searched upward from pointer ptr with wrap NREQ-1 -> 0; req_ready SHALL be all-zero outside IDLE or when no request is pending.
REQ-005 Acceptance edge (IDLE, winner valid): the block SHALL register the winner's a/b/op/mode into add_* and its index into rsp_id, load cnt=LAT, set ptr=(winner+1) mod NREQ, and go to BUSY.
REQ-006 add_* outputs SHALL hold stable from the acceptance edge until the next acceptance edge.
REQ-007 BUSY: cnt SHALL decrement each cycle; in the cycle with cnt==0 the block SHALL capture add_result/add_flag into rsp_result/rsp_flag and go to RESP at that edge.
REQ-008 rsp_valid SHALL be 1 exactly in RESP, first asserted LAT+1 cycles after the acceptance edge.
REQ-009 RESP: rsp_* SHALL hold stable while rsp_ready=0; on rsp_valid&&rsp_ready the FSM SHALL go to IDLE.
REQ-010 No request SHALL be accepted in BUSY or RESP; peak throughput SHALL be one operation per LAT+3 cycles (one IDLE cycle mandatory).
REQ-011 ptr SHALL change only on acceptance; a requester deasserting req_valid before acceptance SHALL leave no state change.
REQ-012 Simultaneous requests: exactly one SHALL be granted; each continuously requesting requester SHALL be served within NREQ grants.
REQ-013 Result and flag SHALL be passed unmodified; the block SHALL perform no arithmetic.

Reset
REQ-014 rstn=0 at a clock edge SHALL force IDLE, ptr=0, cnt=0, add_*=0, rsp_id=0, rsp_result=0, rsp_flag=0, and thereby rsp_valid=0 and req_ready=0 while rstn=0.
REQ-015 Reset during BUSY or RESP SHALL discard the in-flight operation with no response.

Structure
REQ-016 Shared package adder_pkg SHALL hold width, op_width, RES_W=20 and the FSM state enum; adder_arbiter SHALL import it.
REQ-017 Winner selection SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot grant and index), combinational only.

Verification
REQ-018 After reset with LAT=1: only req_valid[2]=1, a=8'd5, b=8'd3, op=0 -> req_ready=4'b0100 for one cycle; rsp_valid rises 2 cycles later with rsp_id=2 and rsp_result equal to the adder model.
REQ-019 All four requesters valid, rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_id matches its grant.
REQ-020 rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0, no acceptance; release -> IDLE next cycle.
REQ-021 rstn=0 for one edge while in BUSY -> rsp_valid never asserts for that op; next request is served with ptr=0 priority (req 0 before req 3).
REQ-022 LAT=0 and LAT=3 builds, single request -> rsp_valid first high 1 and 4 cycles after acceptance; add_* stable throughout.
